// File: rtl/spi_slave.sv
// spi_slave: byte-oriented SPI responder. SPI_CLK/SPI_CSN/SPI_MOSI are
// oversampled in the PCLK domain. Words shift MSB first. A one-word TX
// holding register and an RX strobe form the byte interface.
module spi_slave #(
  parameter logic [1:0]        SPI_MODE   = 2'd3,
  parameter int unsigned       DWIDTH     = 8,
  parameter logic [DWIDTH-1:0] TX_DEFAULT = '1
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic [DWIDTH-1:0] DATA_BYTE_IN,
  input  logic              TX_DV,
  output logic              TX_READY,
  output logic              TX_UNDERRUN,
  output logic              RX_DV,
  output logic [DWIDTH-1:0] DATA_BYTE_OUT,
  input  logic              SPI_CLK,
  input  logic              SPI_CSN,
  input  logic              SPI_MOSI,
  output logic              SPI_MISO,
  output logic              SPI_MISO_OE
);

  localparam logic        CPOL = SPI_MODE[1];
  localparam logic        CPHA = SPI_MODE[0];
  localparam int unsigned CNTW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;

  typedef enum logic [1:0] {RESYNC, IDLE, ACTIVE} state_t;

  state_t            state, next_state;
  logic              sclk_meta, sclk_sync, sclk_d;
  logic              csn_meta, csn_sync, csn_d;
  logic              mosi_meta, mosi_sync;
  logic [1:0]        flush_cnt;
  logic [CNTW-1:0]   bit_cnt;
  logic [DWIDTH-1:0] rx_shift, tx_shift, hold;
  logic              full;
  logic              start, active_sel, load, write;
  logic              lead_edge, trail_edge, sample_edge, shift_edge, csn_fall;

  // Input synchronisers plus one extra stage on SCLK/CSN for edge detection.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      sclk_meta <= CPOL;
      sclk_sync <= CPOL;
      sclk_d    <= CPOL;
      csn_meta  <= 1'b1;
      csn_sync  <= 1'b1;
      csn_d     <= 1'b1;
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
    end else begin
      sclk_meta <= SPI_CLK;
      sclk_sync <= sclk_meta;
      sclk_d    <= sclk_sync;
      csn_meta  <= SPI_CSN;
      csn_sync  <= csn_meta;
      csn_d     <= csn_sync;
      mosi_meta <= SPI_MOSI;
      mosi_sync <= mosi_meta;
    end
  end

  assign lead_edge   = (sclk_d == CPOL) && (sclk_sync != CPOL);
  assign trail_edge  = (sclk_d != CPOL) && (sclk_sync == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign csn_fall    = csn_d & ~csn_sync;
  assign active_sel  = (state == ACTIVE) && !csn_sync;

  // State register, plus a flush counter so RESYNC only trusts csn_sync once
  // the reset values have drained out of the synchroniser (otherwise a CSN
  // that was already low would look like a fresh falling edge).
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= RESYNC;
      flush_cnt <= '0;
    end else begin
      state <= next_state;
      if (flush_cnt != 2'd2) flush_cnt <= flush_cnt + 2'd1;
    end
  end

  // Next-state logic; start marks the IDLE->ACTIVE transition.
  always_comb begin
    next_state = state;
    start      = 1'b0;
    case (state)
      RESYNC: if (flush_cnt == 2'd2 && csn_sync) next_state = IDLE;
      IDLE: begin
        if (csn_fall) begin
          next_state = ACTIVE;
          start      = 1'b1;
        end
      end
      ACTIVE: if (csn_sync) next_state = IDLE;
      default: next_state = RESYNC;
    endcase
  end

  assign load  = (!CPHA && start) || (active_sel && shift_edge && bit_cnt == '0);
  assign write = TX_DV & ~full;

  // TX holding register and output shifter.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      hold        <= '0;
      full        <= 1'b0;
      tx_shift    <= '0;
      TX_UNDERRUN <= 1'b0;
    end else begin
      TX_UNDERRUN <= load & ~full;
      if (write) hold <= DATA_BYTE_IN;
      full <= load ? write : (full | write);
      if (load) tx_shift <= full ? hold : TX_DEFAULT;
      else if (active_sel && shift_edge) tx_shift <= tx_shift << 1;
    end
  end

  // Receive shifter, bit counter and RX strobe.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      bit_cnt       <= '0;
      rx_shift      <= '0;
      DATA_BYTE_OUT <= '0;
      RX_DV         <= 1'b0;
    end else begin
      RX_DV <= 1'b0;
      if (!active_sel) begin
        bit_cnt <= '0;
      end else if (sample_edge) begin
        rx_shift <= {rx_shift[DWIDTH-2:0], mosi_sync};
        if (bit_cnt == CNTW'(DWIDTH-1)) begin
          bit_cnt       <= '0;
          DATA_BYTE_OUT <= {rx_shift[DWIDTH-2:0], mosi_sync};
          RX_DV         <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + CNTW'(1);
        end
      end
    end
  end

  assign SPI_MISO    = tx_shift[DWIDTH-1];
  assign SPI_MISO_OE = (state == ACTIVE);
  assign TX_READY    = ~full;

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: one spi_slave per SPI mode sharing CSN/MOSI/reset, each with
// its own SCLK. Table-driven single-word frames plus hand-written sequences.
`timescale 1ns/1ps
module tb_spi_slave;

  logic       pclk = 1'b0;
  logic       preset;
  logic       csn, mosi;
  logic       sclk     [4];
  logic       tx_dv    [4];
  logic [7:0] din      [4];
  logic       tx_ready [4];
  logic       tx_und   [4];
  logic       rx_dv    [4];
  logic [7:0] dout     [4];
  logic       miso     [4];
  logic       miso_oe  [4];

  always #5 pclk = ~pclk;

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_dut
      spi_slave #(.SPI_MODE(2'(g)), .DWIDTH(8), .TX_DEFAULT(8'hFF)) u_dut (
        .PCLK(pclk), .PRESET(preset),
        .DATA_BYTE_IN(din[g]), .TX_DV(tx_dv[g]), .TX_READY(tx_ready[g]),
        .TX_UNDERRUN(tx_und[g]), .RX_DV(rx_dv[g]), .DATA_BYTE_OUT(dout[g]),
        .SPI_CLK(sclk[g]), .SPI_CSN(csn), .SPI_MOSI(mosi),
        .SPI_MISO(miso[g]), .SPI_MISO_OE(miso_oe[g])
      );
    end
  endgenerate

  int         checks = 0;
  int         errors = 0;
  int         rx_cnt  [4] = '{default: 0};
  int         und_cnt [4] = '{default: 0};
  logic [7:0] rx_log  [4][128];

  // Pulse monitor: logs every RX word and counts underrun pulses.
  always @(negedge pclk) begin
    for (int m = 0; m < 4; m++) begin
      if (rx_dv[m]) begin
        rx_log[m][rx_cnt[m] % 128] <= dout[m];
        rx_cnt[m] <= rx_cnt[m] + 1;
      end
      if (tx_und[m]) und_cnt[m] <= und_cnt[m] + 1;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic half_wait();
    repeat (4) @(negedge pclk);
  endtask

  task automatic write_tx(input int m, input logic [7:0] d);
    check("tx_ready_before_write", 32'(tx_ready[m]), 32'd1);
    din[m]   = d;
    tx_dv[m] = 1'b1;
    @(negedge pclk);
    tx_dv[m] = 1'b0;
  endtask

  logic       snap_oe, snap_miso, snap_ready, snap_rxdv, snap_und;
  logic [7:0] snap_dout;
  logic       ready_mid, oe_last;

  // SPI master: nbits from mo (MSB first), MISO collected into mi. Optional
  // TX write or one-cycle reset pulse at the start of a given bit.
  task automatic frame(input int m, input int nbits, input logic [15:0] mo,
                       input int wr_bit, input logic [7:0] wr_data,
                       input int rst_bit, output logic [15:0] mi);
    logic [1:0] mv;
    logic cpol, cpha;
    mv   = m[1:0];
    cpol = mv[1];
    cpha = mv[0];
    mi   = '0;
    csn  = 1'b0;
    half_wait();
    for (int i = 0; i < nbits; i++) begin
      if (i == wr_bit) begin
        din[m]   = wr_data;
        tx_dv[m] = 1'b1;
        @(negedge pclk);
        tx_dv[m] = 1'b0;
      end
      if (i == rst_bit) begin
        preset = 1'b1;
        @(negedge pclk);
        preset     = 1'b0;
        snap_oe    = miso_oe[m];
        snap_miso  = miso[m];
        snap_ready = tx_ready[m];
        snap_rxdv  = rx_dv[m];
        snap_und   = tx_und[m];
        snap_dout  = dout[m];
      end
      if (!cpha) mosi = mo[nbits-1-i];
      half_wait();
      if (!cpha) mi = {mi[14:0], miso[m]};
      sclk[m] = ~cpol;
      if (cpha) mosi = mo[nbits-1-i];
      half_wait();
      if (cpha) mi = {mi[14:0], miso[m]};
      if (i == 0) ready_mid = tx_ready[m];
      sclk[m] = cpol;
    end
    half_wait();
    oe_last = miso_oe[m];
    csn = 1'b1;
    repeat (8) @(negedge pclk);
  endtask

  typedef struct {
    int         mode;
    logic       wr;
    logic [7:0] txw;
    logic [7:0] mo;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
    int         exp_und;
  } vec_t;

  vec_t vt [6];

  initial begin
    logic [15:0] got;
    logic [7:0]  w, d;
    int          c0, u0;

    // mode 0/2 without a write underrun both at CSN fall and after the last word
    vt[0] = '{3, 1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 0};
    vt[1] = '{3, 1'b0, 8'h00, 8'h55, 8'hFF, 8'h55, 1};
    vt[2] = '{1, 1'b1, 8'hC6, 8'h0F, 8'hC6, 8'h0F, 0};
    vt[3] = '{2, 1'b1, 8'h01, 8'h80, 8'h01, 8'h80, 1};
    vt[4] = '{0, 1'b0, 8'h00, 8'hF0, 8'hFF, 8'hF0, 2};
    vt[5] = '{1, 1'b0, 8'h00, 8'hAA, 8'hFF, 8'hAA, 1};

    preset = 1'b1;
    csn    = 1'b1;
    mosi   = 1'b0;
    for (int m = 0; m < 4; m++) begin
      sclk[m]  = (m >= 2);
      tx_dv[m] = 1'b0;
      din[m]   = '0;
    end
    repeat (3) @(negedge pclk);
    for (int m = 0; m < 4; m++) begin
      check("reset_tx_ready", 32'(tx_ready[m]), 32'd1);
      check("reset_miso_oe", 32'(miso_oe[m]), 32'd0);
      check("reset_miso", 32'(miso[m]), 32'd0);
      check("reset_rx_dv", 32'(rx_dv[m]), 32'd0);
      check("reset_underrun", 32'(tx_und[m]), 32'd0);
      check("reset_data_out", 32'(dout[m]), 32'd0);
    end
    preset = 1'b0;
    repeat (6) @(negedge pclk);

    for (int v = 0; v < 6; v++) begin
      if (vt[v].wr) begin
        write_tx(vt[v].mode, vt[v].txw);
        check("tx_ready_after_write", 32'(tx_ready[vt[v].mode]), 32'd0);
      end
      c0 = rx_cnt[vt[v].mode];
      u0 = und_cnt[vt[v].mode];
      frame(vt[v].mode, 8, {8'h00, vt[v].mo}, -1, 8'h00, -1, got);
      check("vec_miso", 32'(got[7:0]), 32'(vt[v].exp_miso));
      check("vec_rx_count", 32'(rx_cnt[vt[v].mode] - c0), 32'd1);
      check("vec_rx_data", 32'(rx_log[vt[v].mode][c0 % 128]), 32'(vt[v].exp_rx));
      check("vec_underrun", 32'(und_cnt[vt[v].mode] - u0), 32'(vt[v].exp_und));
      check("vec_ready_after_first_edge", 32'(ready_mid), 32'd1);
    end

    // mode 0, two back-to-back words, second TX word written during word 1
    write_tx(0, 8'h81);
    c0 = rx_cnt[0];
    frame(0, 16, 16'h1234, 3, 8'h7E, -1, got);
    check("b2b_miso", 32'(got), 32'h817E);
    check("b2b_rx_count", 32'(rx_cnt[0] - c0), 32'd2);
    check("b2b_rx_word1", 32'(rx_log[0][c0 % 128]), 32'h12);
    check("b2b_rx_word2", 32'(rx_log[0][(c0 + 1) % 128]), 32'h34);

    // abort after 5 bits, then a clean frame
    write_tx(3, 8'h96);
    c0 = rx_cnt[3];
    frame(3, 5, 16'h0016, -1, 8'h00, -1, got);
    check("abort_miso_bits", 32'(got[4:0]), 32'h12);
    check("abort_oe_while_selected", 32'(oe_last), 32'd1);
    check("abort_oe_after", 32'(miso_oe[3]), 32'd0);
    check("abort_no_rx", 32'(rx_cnt[3] - c0), 32'd0);
    write_tx(3, 8'h69);
    frame(3, 8, 16'h00C3, -1, 8'h00, -1, got);
    check("post_abort_miso", 32'(got[7:0]), 32'h69);
    check("post_abort_rx_count", 32'(rx_cnt[3] - c0), 32'd1);
    check("post_abort_rx", 32'(rx_log[3][c0 % 128]), 32'hC3);

    // reset pulse at bit 3 with a pending TX word
    write_tx(3, 8'hE7);
    c0 = rx_cnt[3];
    frame(3, 8, 16'h00FF, 1, 8'h11, 3, got);
    check("midrst_oe", 32'(snap_oe), 32'd0);
    check("midrst_miso", 32'(snap_miso), 32'd0);
    check("midrst_tx_ready", 32'(snap_ready), 32'd1);
    check("midrst_rx_dv", 32'(snap_rxdv), 32'd0);
    check("midrst_underrun", 32'(snap_und), 32'd0);
    check("midrst_data_out", 32'(snap_dout), 32'd0);
    check("midrst_oe_rest_of_frame", 32'(oe_last), 32'd0);
    check("midrst_no_rx", 32'(rx_cnt[3] - c0), 32'd0);
    write_tx(3, 8'h3C);
    frame(3, 8, 16'h005A, -1, 8'h00, -1, got);
    check("post_rst_miso", 32'(got[7:0]), 32'h3C);
    check("post_rst_rx_count", 32'(rx_cnt[3] - c0), 32'd1);
    check("post_rst_rx", 32'(rx_log[3][c0 % 128]), 32'h5A);

    // modes 1 and 2 with random words
    for (int f = 0; f < 50; f++) begin
      for (int k = 1; k <= 2; k++) begin
        w = 8'($urandom);
        d = 8'($urandom);
        write_tx(k, w);
        c0 = rx_cnt[k];
        frame(k, 8, {8'h00, d}, -1, 8'h00, -1, got);
        check("sweep_miso", 32'(got[7:0]), 32'(w));
        check("sweep_rx_count", 32'(rx_cnt[k] - c0), 32'd1);
        check("sweep_rx", 32'(rx_log[k][c0 % 128]), 32'(d));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- Byte-oriented SPI responder. It is the peripheral-side counterpart to the team's spi_master and is used as an on-chip loopback target and as the SPI front end of slave-mode designs.
- Oversamples SPI_CLK, SPI_CSN and SPI_MOSI in the PCLK domain and shifts bytes in and out MSB first.
- Presents a one-byte TX holding register (valid/ready) and an RX strobe that match the spi_master byte interface, so the same FIFO wrappers attach unchanged.

Parameters:
- SPI_MODE, 3, SPI mode: CPOL = SPI_MODE[1], CPHA = SPI_MODE[0].
- DWIDTH, 8, bits per SPI word.
- TX_DEFAULT, 8'hFF, word shifted out on MISO when the TX holding register is empty at a load event.

Ports:
- PCLK  input  1  system clock. All logic is on the rising edge.
- PRESET  input  1  synchronous, active-high reset.
- DATA_BYTE_IN  input  DWIDTH  word to transmit.
- TX_DV  input  1  DATA_BYTE_IN valid.
- TX_READY  output  1  TX holding register empty; write accepted when TX_DV & TX_READY.
- TX_UNDERRUN  output  1  one-cycle pulse when TX_DEFAULT is loaded because the holding register was empty.
- RX_DV  output  1  one-cycle pulse; DATA_BYTE_OUT is valid in that cycle.
- DATA_BYTE_OUT  output  DWIDTH  last fully received word. Held until the next RX_DV.
- SPI_CLK  input  1  serial clock from the master (asynchronous to PCLK).
- SPI_CSN  input  1  active-low chip select.
- SPI_MOSI  input  1  serial data in.
- SPI_MISO  output  1  serial data out, MSB first.
- SPI_MISO_OE  output  1  MISO output enable, high only while selected.

Behaviour:
- Clocking and reset: one clock, PCLK. Reset is synchronous and active-high (PRESET).
- Input synchronisation:
  - SPI_CLK, SPI_CSN and SPI_MOSI each pass through 2 flops.
  - A 3rd flop on SCLK and CSN provides edge detection.
  - Reset values of the synchroniser flops: sclk = CPOL, csn = 1, mosi = 0.
  - Requirement: f(PCLK) >= 8 x f(SPI_CLK). MISO updates 3–4 PCLK after the shift edge.
- Edge definitions:
  - Leading edge: transition away from CPOL. Trailing edge: transition back to CPOL.
  - Sample edge = leading if CPHA = 0, otherwise trailing. Shift edge = the other edge.
- FSM:
  - RESYNC: entered on reset. Moves to IDLE once synced csn = 1. The bus is ignored while in RESYNC, so a reset asserted mid-frame never joins that frame part-way.
  - IDLE: moves to ACTIVE on a synced csn falling edge. bit_cnt <= 0.
  - ACTIVE: moves to IDLE on synced csn = 1, from any bit_cnt. A partial word is discarded: no RX_DV, bit_cnt <= 0. The TX holding register is kept.
- Load event (loads tx_shift from the holding register, else from TX_DEFAULT):
  - CPHA = 0: at the IDLE->ACTIVE transition, and at every shift edge with bit_cnt == 0 after the first word.
  - CPHA = 1: at every shift edge with bit_cnt == 0.
  - At all other shift edges in ACTIVE: tx_shift <= tx_shift << 1.
  - SPI_MISO = tx_shift[DWIDTH-1].
- Sample edge in ACTIVE:
  - rx_shift <= {rx_shift, mosi_s}; bit_cnt increments and wraps at DWIDTH-1 -> 0.
  - On the wrap: DATA_BYTE_OUT <= the completed word, and RX_DV pulses for 1 cycle. There is no back-pressure.
- TX holding register:
  - TX_READY = ~full.
  - A write sets full. A load event clears full.
  - A write and a load event in the same cycle: the load takes the old content if full. If the register was empty, TX_DEFAULT is loaded, TX_UNDERRUN pulses, and the new write is captured for the next word.
- SPI_MISO_OE = 1 only in ACTIVE.
- Reset values: SPI_MISO = 0, SPI_MISO_OE = 0, TX_READY = 1, TX_UNDERRUN = 0, RX_DV = 0, DATA_BYTE_OUT = 0, bit_cnt = 0, state = RESYNC.
- SCLK edges while CSN is high are ignored.

Test Plan:
- Mode 3, PCLK:SCLK = 8: write 8'hA5 before CSN falls; master sends 8'h3C. Required: MISO carries A5 MSB first; one RX_DV pulse with DATA_BYTE_OUT = 3C; TX_READY returns to 1 at the first leading edge.
- Mode 0, back-to-back frame of 2 words: 8'h81 preloaded, 8'h7E written during word 1; MOSI sends 8'h12, 8'h34. Required: MISO = 81 then 7E; RX_DV twice with 12, then 34.
- Underrun: no TX write, master sends 1 word. Required: MISO = FF, one TX_UNDERRUN pulse, RX_DV fires normally.
- Abort: CSN rises after 5 SCLK cycles. Required: no RX_DV, SPI_MISO_OE = 0. The next frame of 8'hC3 receives C3 correctly.
- Reset mid-frame: PRESET asserted for 1 cycle at bit 3. Required: outputs take reset values, the remaining bits are ignored until CSN rises. The following frame of 8'h5A is received as 5A.
- Modes 1 and 2 sweep with random words over 50 frames: RX matches MOSI and MISO matches written words, 100%.
